rr_arbiter4: RTL and testbench

- 4-requester round-robin arbiter with a bounded grant tenure, driving one shared resource.
- Outputs a one-hot grant plus its 2-bit encoded index and a valid flag, so the downstream datapath mux selects on grant_idx directly.
- Sits between four request sources and the shared resource.
- Single clock domain; fully registered outputs.

---
 rtl/rr_arbiter4.sv | 130 +++++++++++++
 tb/tb_rr_arbiter4.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with bounded grant tenure.
// The owner keeps the resource until it drops its request, or until it has held it for
// MAX_HOLD consecutive cycles while someone else is waiting. Outputs are fully registered.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] req_i,
  output logic [3:0] grant_o,
  output logic [1:0] grant_idx_o,
  output logic       grant_valid_o
);

  typedef enum logic [0:0] {StIdle, StOwned} state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       idx_q, idx_d;
  logic             valid_q, valid_d;

  // Scan r from bit start upward, wrapping 3->0. Result is {found, index}.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] j;
    res = 3'b000;
    // Walk the scan order backwards so the earliest set bit is the one left in res.
    for (int i = 3; i >= 0; i--) begin
      j = start + i[1:0];
      if (r[j]) begin
        res = {1'b1, j};
      end
    end
    return res;
  endfunction

  logic       owner_req;
  logic [3:0] others;
  logic [1:0] next_start;
  logic [2:0] pick_idle;
  logic [2:0] pick_next;
  logic       at_limit;

  // Arbitration terms derived from the current owner and the live request vector.
  always_comb begin
    owner_req  = req_i[idx_q];
    others     = req_i & ~(4'b0001 << idx_q);
    next_start = idx_q + 2'd1;
    pick_idle  = pick(req_i, ptr_q);
    pick_next  = pick(others, next_start);
    at_limit   = (hold_q == CNT_W'(MAX_HOLD));
  end

  // Next-state: grant from idle, hand off on release or preemption, else count tenure.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    valid_d = valid_q;

    unique case (state_q)
      StIdle: begin
        // Initial grant leaves the pointer alone.
        if (|req_i) begin
          state_d = StOwned;
          grant_d = 4'b0001 << pick_idle[1:0];
          idx_d   = pick_idle[1:0];
          valid_d = 1'b1;
          hold_d  = CNT_W'(1);
        end
      end

      StOwned: begin
        if (!owner_req) begin
          // Voluntary release; new requests arriving now are visible in the same pick.
          ptr_d = next_start;
          if (pick_next[2]) begin
            grant_d = 4'b0001 << pick_next[1:0];
            idx_d   = pick_next[1:0];
            hold_d  = CNT_W'(1);
          end else begin
            state_d = StIdle;
            grant_d = 4'b0000;
            idx_d   = 2'b00;
            valid_d = 1'b0;
            hold_d  = '0;
          end
        end else if (at_limit && (|others)) begin
          // Tenure exhausted with others waiting: the owner must re-win by rotation.
          ptr_d   = next_start;
          grant_d = 4'b0001 << pick_next[1:0];
          idx_d   = pick_next[1:0];
          hold_d  = CNT_W'(1);
        end else if (!at_limit) begin
          hold_d = hold_q + CNT_W'(1);
        end
        // Sole requester at the limit: keep the grant, counter saturates.
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ptr_q   <= 2'b00;
      hold_q  <= '0;
      grant_q <= 4'b0000;
      idx_q   <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_idx_o   = idx_q;
  assign grant_valid_o = valid_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed scenarios with literal expectations,
// then randomized requests checked every cycle against an integer-level reference model.
module tb_rr_arbiter4;

  localparam int unsigned MaxHold   = 4;
  localparam int          WaitLimit = 3 * MaxHold + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: owner index (-1 = none), priority pointer, tenure count.
  int m_owner;
  int m_ptr;
  int m_hold;
  int wait_cnt[4];

  always #5 clk = ~clk;

  rr_arbiter4 #(
    .MAX_HOLD (MaxHold),
    .CNT_W    (8)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_i         (req),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  function automatic int m_pick(input logic [3:0] r, input int start);
    for (int i = 0; i < 4; i++) begin
      int j;
      j = (start + i) % 4;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_grant();
    logic [3:0] g;
    g = 4'b0000;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    for (int j = 0; j < 4; j++) wait_cnt[j] = 0;
  endtask

  // One clock edge of the arbitration rules, applied to request vector r.
  task automatic model_step(input logic [3:0] r);
    int         k;
    logic [3:0] others;
    if (m_owner < 0) begin
      m_owner = m_pick(r, m_ptr);
      if (m_owner >= 0) m_hold = 1;
    end else begin
      k         = m_owner;
      others    = r;
      others[k] = 1'b0;
      if (!r[k]) begin
        m_ptr   = (k + 1) % 4;
        m_owner = m_pick(others, m_ptr);
        m_hold  = (m_owner >= 0) ? 1 : 0;
      end else if (m_hold == int'(MaxHold) && others != 4'b0000) begin
        m_ptr   = (k + 1) % 4;
        m_owner = m_pick(others, m_ptr);
        m_hold  = 1;
      end else if (m_hold < int'(MaxHold)) begin
        m_hold++;
      end
    end
  endtask

  task automatic check_outputs(input string name, input logic [3:0] exp_g);
    logic [1:0] exp_i;
    exp_i = 2'b00;
    for (int i = 0; i < 4; i++) if (exp_g[i]) exp_i = i[1:0];
    vectors++;
    if (grant !== exp_g || grant_idx !== exp_i || grant_valid !== (|exp_g)) begin
      miscompares++;
      $display("FAIL %s @%0t: got grant=%b idx=%b valid=%b, expected grant=%b idx=%b valid=%b",
               name, $time, grant, grant_idx, grant_valid, exp_g, exp_i, |exp_g);
    end
  endtask

  // Apply r for one cycle, step the model at the edge, compare on the falling edge.
  task automatic cyc(input logic [3:0] r);
    logic [1:0] enc;
    int         worst;
    req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    check_outputs("model", model_grant());

    enc = 2'b00;
    for (int i = 0; i < 4; i++) if (grant[i]) enc = i[1:0];
    vectors++;
    if (!$onehot0(grant) || grant_idx !== enc || grant_valid !== (|grant)) begin
      miscompares++;
      $display("FAIL invariant @%0t: grant=%b idx=%b valid=%b", $time, grant, grant_idx,
               grant_valid);
    end

    worst = 0;
    for (int j = 0; j < 4; j++) begin
      if (r[j] && !grant[j]) wait_cnt[j]++;
      else wait_cnt[j] = 0;
      if (wait_cnt[j] > worst) worst = wait_cnt[j];
    end
    vectors++;
    if (worst > WaitLimit) begin
      miscompares++;
      $display("FAIL starvation @%0t: waited %0d cycles, limit %0d", $time, worst, WaitLimit);
    end
  endtask

  // Half-cycle reset pulse starting just after a falling edge.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outputs("async_clear", 4'b0000);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_outputs("post_reset_idle", model_grant());
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] v;

    rst_n = 1'b0;
    req   = 4'b1111;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset_state", 4'b0000);
    rst_n = 1'b1;
    cyc(4'b1111);
    check_outputs("first_grant", 4'b0001);

    // Each owner holds two cycles, then drops for one: back-to-back rotation.
    for (int k = 0; k < 4; k++) begin
      v = 4'b0001 << k;
      cyc(4'b1111);
      check_outputs("rr_hold", v);
      cyc(4'b1111 & ~v);
      v = 4'b0001 << ((k + 1) % 4);
      check_outputs("rr_handoff", v);
    end

    cyc(4'b0000);
    check_outputs("release_to_idle", 4'b0000);
    cyc(4'b0000);

    // Preemption after exactly MaxHold cycles, then regrant once req[0] drops.
    cyc(4'b0100);
    check_outputs("preempt_hold1", 4'b0100);
    repeat (3) begin
      cyc(4'b0101);
      check_outputs("preempt_hold", 4'b0100);
    end
    cyc(4'b0101);
    check_outputs("preempt_switch", 4'b0001);
    cyc(4'b0100);
    check_outputs("preempt_regrant", 4'b0100);

    // Sole requester keeps the grant indefinitely.
    cyc(4'b1000);
    check_outputs("sole_start", 4'b1000);
    repeat (20) begin
      cyc(4'b1000);
      check_outputs("sole_sat", 4'b1000);
    end

    // Pointer wraps to 3 after owner 2 releases.
    cyc(4'b0000);
    check_outputs("wrap_idle", 4'b0000);
    cyc(4'b0100);
    check_outputs("wrap_owner2", 4'b0100);
    cyc(4'b0000);
    check_outputs("wrap_release", 4'b0000);
    cyc(4'b1001);
    check_outputs("wrap_first3", 4'b1000);
    cyc(4'b0001);
    check_outputs("wrap_then0", 4'b0001);

    // Asynchronous reset in the middle of a tenure.
    cyc(4'b0100);
    check_outputs("mid_owner2", 4'b0100);
    mid_reset();
    cyc(4'b0100);
    check_outputs("reset_regrant", 4'b0100);

    // Randomized traffic: requests toggle sparsely so tenures and preemptions both occur.
    r = req;
    for (int n = 0; n < 3000; n++) begin
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(7) == 0) r[j] = ~r[j];
      end
      if ($urandom_range(399) == 0) mid_reset();
      cyc(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
